// File: rtl/adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// adc_capture_ctrl
//   Capture sequencer for one ADC AXI-Stream channel. An arm command latches a
//   capture length and trigger mode; after an immediate or external trigger the
//   following stream words are written to a single-port sample buffer at
//   consecutive addresses, then done/irq are raised.
//
// Ports
//   s0_axis_adc_aclk     ADC clock, the only clock
//   s0_axis_adc_aresetn  synchronous active-low reset
//   s_axis_tdata/tvalid  ADC stream input; s_axis_tready is never deasserted
//                        after reset (the ADC is never stalled)
//   cfg_length           words to capture (latched on arm, clamped to depth)
//   cfg_trig_ext         0 = immediate, 1 = wait for trig_in (latched on arm)
//   arm / abort          single-cycle command pulses (abort wins)
//   trig_in              external trigger level, already in this clock domain
//   mem_we/addr/wdata    registered buffer write port
//   busy                 high while ARMED or CAPTURE
//   done                 sticky completion flag
//   irq                  one-cycle pulse on entry to DONE
//   captured_count       words written in the current or last capture
// -----------------------------------------------------------------------------
module adc_capture_ctrl #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  s0_axis_adc_aclk,
   input  logic                  s0_axis_adc_aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [ADDR_WIDTH:0]   cfg_length,
   input  logic                  cfg_trig_ext,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  trig_in,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  irq,
   output logic [ADDR_WIDTH:0]   captured_count
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [CW-1:0] MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [CW-1:0]           len_r;
   logic                    trig_ext_r;
   logic [CW-1:0]           len_clamp_s;
   logic [CW-1:0]           count_inc_s;
   logic                    arm_go_s;
   logic                    accept_s;

   logic                    we_d_s;
   logic [ADDR_WIDTH-1:0]   addr_d_s;
   logic [DATA_WIDTH-1:0]   wdata_d_s;
   logic [CW-1:0]           count_d_s;
   logic                    busy_d_s;
   logic                    done_d_s;
   logic                    irq_d_s;

   logic                    tready_r;
   logic                    mem_we_r;
   logic [ADDR_WIDTH-1:0]   mem_addr_r;
   logic [DATA_WIDTH-1:0]   mem_wdata_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    irq_r;
   logic [CW-1:0]           count_r;

   // Command/beat qualification: clamp, effective arm, and beats to be written.
   always_comb begin
      len_clamp_s = cfg_length;
      arm_go_s    = 1'b0;
      accept_s    = 1'b0;
      count_inc_s = count_r + CNT_ONE;
      if (cfg_length > MAX_LEN) begin
         len_clamp_s = MAX_LEN;
      end else begin
         len_clamp_s = cfg_length;
      end
      // abort suppresses both a pending arm and the beat of the same cycle
      if (abort) begin
         arm_go_s = 1'b0;
         accept_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: arm_go_s = arm;
            ST_ARMED:         accept_s = s_axis_tvalid && (!trig_ext_r || trig_in);
            ST_CAPTURE:       accept_s = s_axis_tvalid;
            default: begin
               arm_go_s = 1'b0;
               accept_s = 1'b0;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge s0_axis_adc_aclk) begin
      if (!s0_axis_adc_aresetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      if (abort) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (arm_go_s) begin
                  state_nxt_s = (len_clamp_s == CNT_ZERO) ? ST_DONE : ST_ARMED;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            ST_ARMED: begin
               if (accept_s) begin
                  state_nxt_s = (len_r == CNT_ONE) ? ST_DONE : ST_CAPTURE;
               end else begin
                  state_nxt_s = ST_ARMED;
               end
            end
            ST_CAPTURE: begin
               if (accept_s && (count_inc_s == len_r)) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_CAPTURE;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Output logic: next values for the registered write port and status.
   always_comb begin
      we_d_s    = accept_s;
      addr_d_s  = mem_addr_r;
      wdata_d_s = mem_wdata_r;
      count_d_s = count_r;
      if (accept_s) begin
         // count is cleared on arm, so it is also the write address in ARMED
         addr_d_s  = count_r[ADDR_WIDTH-1:0];
         wdata_d_s = s_axis_tdata;
         count_d_s = count_inc_s;
      end else if (arm_go_s) begin
         count_d_s = CNT_ZERO;
      end else begin
         count_d_s = count_r;
      end
      busy_d_s = (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_CAPTURE);
      done_d_s = (state_nxt_s == ST_DONE);
      // a fresh arm from DONE (length 0) re-enters DONE and pulses again
      irq_d_s  = done_d_s && ((state_r != ST_DONE) || arm_go_s);
   end

   // Registered outputs and latched capture configuration.
   always_ff @(posedge s0_axis_adc_aclk) begin
      if (!s0_axis_adc_aresetn) begin
         tready_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_WIDTH{1'b0}};
         mem_wdata_r <= {DATA_WIDTH{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         irq_r       <= 1'b0;
         count_r     <= CNT_ZERO;
         len_r       <= CNT_ZERO;
         trig_ext_r  <= 1'b0;
      end else begin
         tready_r    <= 1'b1;
         mem_we_r    <= we_d_s;
         mem_addr_r  <= addr_d_s;
         mem_wdata_r <= wdata_d_s;
         busy_r      <= busy_d_s;
         done_r      <= done_d_s;
         irq_r       <= irq_d_s;
         count_r     <= count_d_s;
         if (arm_go_s) begin
            len_r      <= len_clamp_s;
            trig_ext_r <= cfg_trig_ext;
         end
      end
   end

   assign s_axis_tready  = tready_r;
   assign mem_we         = mem_we_r;
   assign mem_addr       = mem_addr_r;
   assign mem_wdata      = mem_wdata_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign irq            = irq_r;
   assign captured_count = count_r;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_capture_ctrl
//   Self-checking bench for adc_capture_ctrl. A behavioural model tracks the
//   capture as "waiting for trigger / capturing / finished" with plain integers
//   and predicts every output after each clock edge; directed scenarios add
//   end-of-scenario checks against fixed expected numbers.
// -----------------------------------------------------------------------------
module tb_adc_capture_ctrl;

   localparam int DW = 256;
   localparam int AW = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic [AW:0]   cfg_length;
   logic          cfg_trig_ext;
   logic          arm;
   logic          abort;
   logic          trig_in;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          busy;
   logic          done;
   logic          irq;
   logic [AW:0]   captured_count;

   int total = 0;
   int bad   = 0;

   // reference model
   int            m_len, m_count, m_addr;
   bit            m_ext, m_wait, m_cap, m_done, m_irq, m_we, m_tready;
   logic [DW-1:0] m_data;

   // observed write statistics
   int n_writes;
   int last_addr;

   always #5 clk = ~clk;

   adc_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .s0_axis_adc_aclk    (clk),
      .s0_axis_adc_aresetn (rstn),
      .s_axis_tdata        (tdata),
      .s_axis_tvalid       (tvalid),
      .s_axis_tready       (tready),
      .cfg_length          (cfg_length),
      .cfg_trig_ext        (cfg_trig_ext),
      .arm                 (arm),
      .abort               (abort),
      .trig_in             (trig_in),
      .mem_we              (mem_we),
      .mem_addr            (mem_addr),
      .mem_wdata           (mem_wdata),
      .busy                (busy),
      .done                (done),
      .irq                 (irq),
      .captured_count      (captured_count)
   );

   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   // Predict outputs after the current edge from the inputs sampled at it.
   task automatic model_step();
      int req;
      m_we  = 1'b0;
      m_irq = 1'b0;
      if (!rstn) begin
         m_tready = 1'b0; m_wait = 1'b0; m_cap = 1'b0; m_done = 1'b0;
         m_count = 0; m_addr = 0; m_data = '0;
      end else begin
         m_tready = 1'b1;
         if (abort) begin
            m_wait = 1'b0; m_cap = 1'b0; m_done = 1'b0;
         end else if (m_wait || m_cap) begin
            if (tvalid && (m_cap || !m_ext || trig_in)) begin
               m_we = 1'b1; m_addr = m_count; m_data = tdata;
               m_count++;
               m_wait = 1'b0; m_cap = 1'b1;
               if (m_count == m_len) begin
                  m_cap = 1'b0; m_done = 1'b1; m_irq = 1'b1;
               end
            end
         end else if (arm) begin
            req     = int'(cfg_length);
            m_len   = (req > DEPTH) ? DEPTH : req;
            m_ext   = cfg_trig_ext;
            m_count = 0;
            m_done  = 1'b0;
            if (m_len == 0) begin
               m_done = 1'b1; m_irq = 1'b1;
            end else begin
               m_wait = 1'b1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_val("tready", DW'(tready), DW'(m_tready));
      check_val("mem_we", DW'(mem_we), DW'(m_we));
      check_val("busy",   DW'(busy),   DW'(m_wait || m_cap));
      check_val("done",   DW'(done),   DW'(m_done));
      check_val("irq",    DW'(irq),    DW'(m_irq));
      check_val("count",  DW'(captured_count), DW'(m_count));
      check_val("addr",   DW'(mem_addr), DW'(m_addr));
      check_val("wdata",  mem_wdata, m_data);
      if (mem_we === 1'b1) begin
         n_writes++;
         last_addr = int'(mem_addr);
      end
   endtask

   task automatic cyc(input bit a, input bit ab, input bit v, input bit t, input logic [DW-1:0] d);
      arm = a; abort = ab; tvalid = v; trig_in = t; tdata = d;
      tick();
   endtask

   initial begin
      rstn = 1'b0; tdata = '0; tvalid = 1'b0; cfg_length = '0; cfg_trig_ext = 1'b0;
      arm = 1'b0; abort = 1'b0; trig_in = 1'b0;
      m_len = 0; m_count = 0; m_addr = 0; m_data = '0; m_ext = 1'b0;
      m_wait = 1'b0; m_cap = 1'b0; m_done = 1'b0; m_irq = 1'b0; m_we = 1'b0; m_tready = 1'b0;
      n_writes = 0; last_addr = -1;

      repeat (3) tick();
      check_val("rst_tready_low", DW'(tready), DW'(0));
      rstn = 1'b1;
      tick();
      check_val("tready_after_release", DW'(tready), DW'(1));

      // immediate mode, length 8, data = beat index
      cfg_length = 11'd8; cfg_trig_ext = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      check_val("s1_busy", DW'(busy), DW'(1));
      n_writes = 0;
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, DW'(i));
      check_val("s1_writes", DW'(n_writes), DW'(8));
      check_val("s1_last_addr", DW'(last_addr), DW'(7));
      check_val("s1_last_data", mem_wdata, DW'(7));
      check_val("s1_done", DW'(done), DW'(1));
      check_val("s1_irq", DW'(irq), DW'(1));
      check_val("s1_count", DW'(captured_count), DW'(8));
      cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check_val("s1_irq_drop", DW'(irq), DW'(0));

      // external trigger, length 4, tvalid toggling, trigger on beat 5
      cfg_length = 11'd4; cfg_trig_ext = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      n_writes = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) check_val("s2_pretrig_writes", DW'(n_writes), DW'(0));
         cyc(1'b0, 1'b0, (i % 2) == 0, i == 10, DW'(i / 2));
      end
      check_val("s2_writes", DW'(n_writes), DW'(4));
      check_val("s2_last_addr", DW'(last_addr), DW'(3));
      check_val("s2_last_data", mem_wdata, DW'(8));

      // length 0, then an oversized length that clamps to the buffer depth
      cfg_length = 11'd0; cfg_trig_ext = 1'b0;
      n_writes = 0;
      cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
      check_val("s3_zero_done", DW'(done), DW'(1));
      check_val("s3_zero_irq", DW'(irq), DW'(1));
      cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check_val("s3_zero_writes", DW'(n_writes), DW'(0));
      cfg_length = 11'(DEPTH + 5);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < DEPTH + 40; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      check_val("s3_big_writes", DW'(n_writes), DW'(1024));
      check_val("s3_big_last_addr", DW'(last_addr), DW'(1023));
      check_val("s3_big_count", DW'(captured_count), DW'(1024));

      // abort at beat 3 of a length-16 capture, then restart
      cfg_length = 11'd16; cfg_trig_ext = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      n_writes = 0;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      cyc(1'b0, 1'b1, 1'b1, 1'b0, rnd_data());
      check_val("s4_busy", DW'(busy), DW'(0));
      cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      check_val("s4_writes", DW'(n_writes), DW'(3));
      check_val("s4_done", DW'(done), DW'(0));
      check_val("s4_count", DW'(captured_count), DW'(3));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      check_val("s4_restart_addr", DW'(mem_addr), DW'(0));
      check_val("s4_restart_we", DW'(mem_we), DW'(1));
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

      // arm+abort together in IDLE, then arm during CAPTURE
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      check_val("s5_busy", DW'(busy), DW'(0));
      cfg_length = 11'd6;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      n_writes = 0;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      cfg_length = 11'd2;
      cyc(1'b1, 1'b0, 1'b1, 1'b0, rnd_data());
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      check_val("s5_writes", DW'(n_writes), DW'(6));
      check_val("s5_last_addr", DW'(last_addr), DW'(5));

      // reset asserted mid-capture
      cfg_length = 11'd20;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      rstn = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      check_val("s6_we", DW'(mem_we), DW'(0));
      check_val("s6_busy", DW'(busy), DW'(0));
      check_val("s6_count", DW'(captured_count), DW'(0));
      check_val("s6_tready", DW'(tready), DW'(0));
      n_writes = 0;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      rstn = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      check_val("s6_tready_back", DW'(tready), DW'(1));
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, rnd_data());
      check_val("s6_no_writes", DW'(n_writes), DW'(0));

      // randomized soak against the model
      for (int i = 0; i < 3000; i++) begin
         cfg_length   = 11'($urandom_range(0, 12));
         cfg_trig_ext = 1'($urandom_range(0, 1));
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rnd_data());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
